// File: rtl/sobel_frame_ctrl.sv
// Frame-level controller for the Sobel edge pipeline: tracks pixel/line position,
// latches a per-frame threshold, delays Vs by the datapath latency and flags malformed frames.
module sobel_frame_ctrl #(
    parameter int IMAGE_W  = 640,
    parameter int IMAGE_H  = 480,
    parameter int PIPE_LAT = 12
) (
    input  logic        InVideoClk,
    input  logic        InVideoRstN,
    input  logic        InEnable,
    input  logic        InVideoVs,
    input  logic        InVideoDe,
    input  logic [7:0]  InThreshold,
    output logic        OutClr,
    output logic        OutVs,
    output logic [7:0]  OutThreshold,
    output logic [15:0] OutPixCnt,
    output logic [15:0] OutLineCnt,
    output logic        OutFrameDone,
    output logic [1:0]  OutState,
    output logic [2:0]  OutErr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        DRAIN   = 2'd3
    } ctrlState_t;

    localparam logic [15:0] LINE_W     = 16'(IMAGE_W);
    localparam logic [15:0] LAST_LINE  = 16'(IMAGE_H - 1);
    localparam logic [4:0]  DRAIN_LAST = 5'(PIPE_LAT - 1);

    ctrlState_t          stateR;
    ctrlState_t          stateS;
    logic [PIPE_LAT-1:0] vsPipeR;
    logic                deR;
    logic [4:0]          drainR;
    logic [4:0]          drainS;
    logic [15:0]         pixS;
    logic [15:0]         lineS;
    logic                clrS;
    logic                doneS;
    logic [2:0]          errS;
    logic [7:0]          thrS;
    logic                vsRiseS;
    logic                deFallS;

    // The first Vs stage doubles as the previous-Vs sample for edge detection.
    assign vsRiseS  = InVideoVs & ~vsPipeR[0];
    assign deFallS  = deR & ~InVideoDe;
    assign OutVs    = vsPipeR[PIPE_LAT-1];
    assign OutState = stateR;

    // Next-state and next-output decode for the frame FSM.
    always_comb begin
        stateS = stateR;
        pixS   = OutPixCnt;
        lineS  = OutLineCnt;
        drainS = drainR;
        clrS   = 1'b0;
        doneS  = 1'b0;
        errS   = OutErr;
        thrS   = OutThreshold;
        if (!InEnable) begin
            stateS = IDLE;
            pixS   = 16'd0;
            lineS  = 16'd0;
            drainS = 5'd0;
        end else begin
            case (stateR)
                IDLE: begin
                    stateS = WAIT_VS;
                    errS   = 3'b000;
                end
                WAIT_VS: begin
                    if (InVideoDe) errS[1] = 1'b1;
                    else           errS[1] = OutErr[1];
                end
                ACTIVE: begin
                    if (vsRiseS) begin
                        errS[2] = 1'b1;
                    end else if (InVideoDe) begin
                        pixS = (OutPixCnt == 16'hFFFF) ? OutPixCnt : OutPixCnt + 16'd1;
                    end else if (deFallS) begin
                        if (OutPixCnt < LINE_W)      errS[0] = 1'b1;
                        else if (OutPixCnt > LINE_W) errS[1] = 1'b1;
                        else                         errS    = OutErr;
                        pixS  = 16'd0;
                        lineS = OutLineCnt + 16'd1;
                        if (OutLineCnt == LAST_LINE) begin
                            stateS = DRAIN;
                            drainS = 5'd0;
                        end else begin
                            stateS = ACTIVE;
                        end
                    end else begin
                        pixS = OutPixCnt;
                    end
                end
                DRAIN: begin
                    if (InVideoDe) errS[1] = 1'b1;
                    else           errS[1] = OutErr[1];
                    // A Vs edge here is deliberately ignored; the drain always runs to completion.
                    if (drainR == DRAIN_LAST) begin
                        doneS  = 1'b1;
                        stateS = WAIT_VS;
                        drainS = 5'd0;
                    end else begin
                        drainS = drainR + 5'd1;
                    end
                end
                default: begin
                    stateS = IDLE;
                end
            endcase
            if (vsRiseS && (stateR == WAIT_VS || stateR == ACTIVE)) begin
                stateS = ACTIVE;
                clrS   = 1'b1;
                thrS   = InThreshold;
                pixS   = 16'd0;
                lineS  = 16'd0;
            end else begin
                clrS = 1'b0;
            end
        end
    end

    // State, output and Vs delay-line registers with synchronous active-low reset.
    always_ff @(posedge InVideoClk) begin
        if (!InVideoRstN) begin
            stateR       <= IDLE;
            vsPipeR      <= '0;
            deR          <= 1'b0;
            drainR       <= 5'd0;
            OutClr       <= 1'b0;
            OutThreshold <= 8'd0;
            OutPixCnt    <= 16'd0;
            OutLineCnt   <= 16'd0;
            OutFrameDone <= 1'b0;
            OutErr       <= 3'b000;
        end else begin
            stateR       <= stateS;
            vsPipeR[0]   <= InVideoVs;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vsPipeR[i] <= vsPipeR[i-1];
            end
            deR          <= InVideoDe;
            drainR       <= drainS;
            OutClr       <= clrS;
            OutThreshold <= thrS;
            OutPixCnt    <= pixS;
            OutLineCnt   <= lineS;
            OutFrameDone <= doneS;
            OutErr       <= errS;
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench: two controllers (PIPE_LAT 3 and 5) share one directed stimulus
// and are compared every cycle against a timestamp-based frame model plus literal checkpoints.
module tb_sobel_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int LA = 3;
    localparam int LB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN, en, vs, de;
    logic [7:0]  thr;
    logic        aClr, aVs, aDone, bClr, bVs, bDone;
    logic [7:0]  aThr, bThr;
    logic [15:0] aPix, aLine, bPix, bLine;
    logic [1:0]  aState, bState;
    logic [2:0]  aErr, bErr;

    sobel_frame_ctrl #(.IMAGE_W(W), .IMAGE_H(H), .PIPE_LAT(LA)) dutA (
        .InVideoClk(clk), .InVideoRstN(rstN), .InEnable(en), .InVideoVs(vs), .InVideoDe(de),
        .InThreshold(thr), .OutClr(aClr), .OutVs(aVs), .OutThreshold(aThr), .OutPixCnt(aPix),
        .OutLineCnt(aLine), .OutFrameDone(aDone), .OutState(aState), .OutErr(aErr));

    sobel_frame_ctrl #(.IMAGE_W(W), .IMAGE_H(H), .PIPE_LAT(LB)) dutB (
        .InVideoClk(clk), .InVideoRstN(rstN), .InEnable(en), .InVideoVs(vs), .InVideoDe(de),
        .InThreshold(thr), .OutClr(bClr), .OutVs(bVs), .OutThreshold(bThr), .OutPixCnt(bPix),
        .OutLineCnt(bLine), .OutFrameDone(bDone), .OutState(bState), .OutErr(bErr));

    typedef struct packed {
        int ph; int pix; int line; int err; int thr; int clr; int done; int doneAt;
    } mdl_t;

    mdl_t mA = '0;
    mdl_t mB = '0;
    int   edgeIdx = 0;
    logic pVs = 1'b0;
    logic pDe = 1'b0;
    bit   vsH  [0:2047];
    bit   rstH [0:2047];
    int   nChecks = 0;
    int   nFail = 0;

    // Frame model: the drain is a deadline (fall edge + latency), not a counter.
    function automatic mdl_t mstep(mdl_t m, int lat, int k, logic r, logic e, logic v,
                                   logic d, logic pv, logic pd, logic [7:0] t);
        mdl_t n;
        logic rise;
        n = m;
        n.clr = 0;
        n.done = 0;
        rise = v && !pv;
        if (!r) return '0;
        if (!e) begin
            n.ph = 0; n.pix = 0; n.line = 0;
            return n;
        end
        case (m.ph)
            0: begin n.ph = 1; n.err = 0; end
            1: if (d) n.err = n.err | 2;
            2: if (!rise) begin
                if (d) begin
                    if (n.pix < 65535) n.pix = n.pix + 1;
                end else if (pd) begin
                    if (m.pix < W) n.err = n.err | 1;
                    if (m.pix > W) n.err = n.err | 2;
                    n.pix = 0;
                    n.line = m.line + 1;
                    if (n.line == H) begin n.ph = 3; n.doneAt = k + lat; end
                end
            end
            3: begin
                if (d) n.err = n.err | 2;
                if (k == m.doneAt) begin n.done = 1; n.ph = 1; end
            end
            default: n.ph = 0;
        endcase
        if (rise && (m.ph == 1 || m.ph == 2)) begin
            if (m.ph == 2) n.err = n.err | 4;
            n.ph = 2; n.clr = 1; n.thr = t; n.pix = 0; n.line = 0;
        end
        return n;
    endfunction

    // Vs seen through a lat-stage delay line; any reset inside the window empties it.
    function automatic logic expVs(int lat, int k);
        if (k - lat + 1 < 0) return 1'b0;
        for (int j = k - lat + 1; j <= k; j++) if (!rstH[j]) return 1'b0;
        return vsH[k - lat + 1];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nChecks = nChecks + 1;
        if (act != exp) begin
            nFail = nFail + 1;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string id, input logic c, input logic v, input logic [7:0] t,
                       input logic [15:0] p, input logic [15:0] l, input logic dn,
                       input logic [1:0] s, input logic [2:0] e, input mdl_t m, input logic ev);
        check({id, ".OutState"}, int'(s), m.ph);
        check({id, ".OutClr"}, int'(c), m.clr);
        check({id, ".OutVs"}, int'(v), int'(ev));
        check({id, ".OutThreshold"}, int'(t), m.thr);
        check({id, ".OutPixCnt"}, int'(p), m.pix);
        check({id, ".OutLineCnt"}, int'(l), m.line);
        check({id, ".OutFrameDone"}, int'(dn), m.done);
        check({id, ".OutErr"}, int'(e), m.err);
    endtask

    // Model update on every active edge from the inputs the DUTs sample.
    always @(posedge clk) begin
        if (edgeIdx < 2048) begin
            vsH[edgeIdx]  <= vs;
            rstH[edgeIdx] <= rstN;
        end
        pVs     <= rstN ? vs : 1'b0;
        pDe     <= rstN ? de : 1'b0;
        mA      <= mstep(mA, LA, edgeIdx, rstN, en, vs, de, pVs, pDe, thr);
        mB      <= mstep(mB, LB, edgeIdx, rstN, en, vs, de, pVs, pDe, thr);
        edgeIdx <= edgeIdx + 1;
    end

    // Cycle-by-cycle comparison of both DUTs against the model, away from the active edge.
    always @(negedge clk) begin
        if (edgeIdx > 0 && edgeIdx < 2048) begin
            cmp("A", aClr, aVs, aThr, aPix, aLine, aDone, aState, aErr, mA, expVs(LA, edgeIdx - 1));
            cmp("B", bClr, bVs, bThr, bPix, bLine, bDone, bState, bErr, mB, expVs(LB, edgeIdx - 1));
        end
    end

    task automatic cyc(input logic v, input logic d);
        vs = v;
        de = d;
        @(negedge clk);
    endtask

    task automatic fullLine(input int n);
        repeat (n) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        rstN = 1'b0; en = 1'b0; vs = 1'b0; de = 1'b0; thr = 8'h40;
        repeat (3) cyc(1'b0, 1'b0);
        check("reset.state", int'(aState), 0);
        check("reset.err", int'(aErr), 0);
        check("reset.thr", int'(aThr), 0);
        check("reset.vsB", int'(bVs), 0);
        rstN = 1'b1; en = 1'b1;
        cyc(1'b0, 1'b0);
        check("enable.waitvs", int'(aState), 1);
        cyc(1'b0, 1'b0);

        // nominal 4x2 frame
        cyc(1'b1, 1'b0);
        check("nom.clr", int'(aClr), 1);
        check("nom.active", int'(aState), 2);
        check("nom.thr", int'(aThr), 8'h40);
        cyc(1'b0, 1'b0);
        check("nom.clrlow", int'(aClr), 0);
        repeat (4) cyc(1'b0, 1'b1);
        check("nom.pix4", int'(aPix), 4);
        cyc(1'b0, 1'b0);
        check("nom.line1", int'(aLine), 1);
        check("nom.pix0", int'(aPix), 0);
        fullLine(4);
        check("nom.drain", int'(aState), 3);
        check("nom.line2", int'(aLine), 2);
        repeat (2) cyc(1'b0, 1'b0);
        check("nom.notyet", int'(aDone), 0);
        cyc(1'b0, 1'b0);
        check("nom.doneA", int'(aDone), 1);
        check("nom.modelDone", mA.done, 1);
        check("nom.backWait", int'(aState), 1);
        check("nom.errA", int'(aErr), 0);
        cyc(1'b0, 1'b0);
        check("nom.doneBearly", int'(bDone), 0);
        cyc(1'b0, 1'b0);
        check("nom.doneB", int'(bDone), 1);
        repeat (2) cyc(1'b0, 1'b0);

        // short line, then threshold changed mid-frame
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        fullLine(3);
        check("short.err", int'(aErr), 3'b001);
        thr = 8'h80;
        cyc(1'b0, 1'b0);
        check("thr.hold", int'(aThr), 8'h40);
        fullLine(4);
        repeat (3) cyc(1'b0, 1'b0);
        check("short.done", int'(aDone), 1);
        check("thr.holdEnd", int'(aThr), 8'h40);
        repeat (4) cyc(1'b0, 1'b0);

        // new frame picks up threshold; Vs during line 1 aborts
        cyc(1'b1, 1'b0);
        check("thr.new", int'(aThr), 8'h80);
        check("thr.clr", int'(aClr), 1);
        cyc(1'b0, 1'b0);
        fullLine(4);
        check("abort.line1", int'(aLine), 1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        check("abort.err", int'(aErr), 3'b101);
        check("abort.clr", int'(aClr), 1);
        check("abort.line0", int'(aLine), 0);
        check("abort.active", int'(aState), 2);
        cyc(1'b0, 1'b0);

        // disable keeps errors; re-enable clears them
        en = 1'b0;
        cyc(1'b0, 1'b0);
        check("dis.idle", int'(aState), 0);
        check("dis.errSticky", int'(aErr), 3'b101);
        en = 1'b1;
        cyc(1'b0, 1'b0);
        check("en.errClr", int'(aErr), 0);

        // DE while waiting for Vs
        cyc(1'b0, 1'b1);
        check("waitDe.err", int'(aErr), 3'b010);
        check("waitDe.pix", int'(aPix), 0);
        cyc(1'b0, 1'b0);

        // Vs rise during drain is missed
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        fullLine(4);
        fullLine(4);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        check("drainVs.stillDrain", int'(aState), 3);
        cyc(1'b1, 1'b0);
        check("drainVs.done", int'(aDone), 1);
        repeat (3) cyc(1'b1, 1'b0);
        check("drainVs.missed", int'(aState), 1);
        check("drainVs.noClr", int'(aClr), 0);
        repeat (2) cyc(1'b0, 1'b0);

        // Vs delay line in IDLE
        en = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0);
        check("vsdly.A", int'(aVs), 1);
        check("vsdly.Bearly", int'(bVs), 0);
        cyc(1'b0, 1'b0);
        check("vsdly.Aoff", int'(aVs), 0);
        cyc(1'b0, 1'b0);
        check("vsdly.B", int'(bVs), 1);
        cyc(1'b0, 1'b0);
        check("vsdly.Boff", int'(bVs), 0);
        en = 1'b1;
        repeat (2) cyc(1'b0, 1'b0);

        // one-clock reset mid-frame
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        fullLine(4);
        repeat (2) cyc(1'b0, 1'b1);
        rstN = 1'b0;
        cyc(1'b0, 1'b0);
        check("rst.state", int'(aState), 0);
        check("rst.line", int'(aLine), 0);
        check("rst.pix", int'(aPix), 0);
        check("rst.thr", int'(aThr), 0);
        check("rst.done", int'(aDone), 0);
        rstN = 1'b1;
        cyc(1'b0, 1'b0);
        check("rst.resume", int'(aState), 1);
        repeat (8) cyc(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 The block SHALL have parameter IMAGE_W, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter IMAGE_H, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter PIPE_LAT, default 12, range 1..31, meaning the Sobel datapath latency in clocks.
REQ-004 The block SHALL have port InVideoClk, input, 1, the single clock.
REQ-005 The block SHALL have port InVideoRstN, input, 1, reset; synchronous, active-low.
REQ-006 The block SHALL have port InEnable, input, 1, controller enable.
REQ-007 The block SHALL have port InVideoVs, input, 1, frame sync; active-high; rising edge marks frame start.
REQ-008 The block SHALL have port InVideoDe, input, 1, input pixel valid.
REQ-009 The block SHALL have port InThreshold, input, 8, requested edge threshold.
REQ-010 The block SHALL have port OutClr, output, 1, one-cycle clear pulse to the line-buffer matrix.
REQ-011 The block SHALL have port OutVs, output, 1, InVideoVs delayed by exactly PIPE_LAT clocks.
REQ-012 The block SHALL have port OutThreshold, output, 8, frame-stable shadow copy of InThreshold.
REQ-013 The block SHALL have port OutPixCnt, output, 16, pixel index within the current line.
REQ-014 The block SHALL have port OutLineCnt, output, 16, current line index.
REQ-015 The block SHALL have port OutFrameDone, output, 1, one-cycle pulse when a frame has fully drained.
REQ-016 The block SHALL have port OutState, output, 2, current FSM state encoding.
REQ-017 The block SHALL have port OutErr, output, 3, sticky errors: [0] short line, [1] long line, [2] frame aborted.

Function
REQ-018 The FSM SHALL have four states, encoded in OutState as IDLE=0, WAIT_VS=1, ACTIVE=2, DRAIN=3.
REQ-019 IDLE SHALL go to WAIT_VS when InEnable=1; any state SHALL go to IDLE on the clock after InEnable=0, with counters zeroed.
REQ-020 The block SHALL detect a Vs rising edge as the registered previous Vs=0 and current InVideoVs=1.
REQ-021 WAIT_VS SHALL go to ACTIVE on a Vs rising edge, registering in the same edge: OutClr=1 for one cycle, OutThreshold<=InThreshold, OutPixCnt=0, OutLineCnt=0.
REQ-022 In ACTIVE, each DE=1 cycle SHALL increment OutPixCnt, saturating at 0xFFFF.
REQ-023 On a DE falling edge (previous DE=1, current DE=0):
  - OutPixCnt SHALL reset to 0 and OutLineCnt SHALL increment.
  - A completed line count below IMAGE_W SHALL set OutErr[0]; above IMAGE_W SHALL set OutErr[1].
REQ-024 When the DE falling edge completes line IMAGE_H-1, the FSM SHALL go to DRAIN.
REQ-025 DRAIN SHALL count PIPE_LAT clocks and then pulse OutFrameDone for one cycle, moving to WAIT_VS in that same cycle.
REQ-026 A Vs rising edge in ACTIVE SHALL set OutErr[2] and restart the frame exactly as in REQ-021, staying in ACTIVE.
REQ-027 A Vs rising edge in DRAIN SHALL not shorten the drain; that frame start SHALL be missed and the block SHALL wait for the next Vs in WAIT_VS.
REQ-028 DE=1 in DRAIN or WAIT_VS SHALL set OutErr[1] and SHALL NOT change the counters.
REQ-029 OutThreshold SHALL change only at a frame start (REQ-021 or REQ-026).
REQ-030 OutVs SHALL be a PIPE_LAT-deep shift register that runs in every state.
REQ-031 OutErr bits SHALL be sticky and SHALL clear only on reset or on an IDLE->WAIT_VS transition.

Reset
REQ-032 While InVideoRstN=0 at a clock edge, the block SHALL hold state IDLE and all outputs 0, including OutThreshold, OutErr, and every OutVs shift stage.
REQ-033 Reset mid-frame SHALL abort without any OutFrameDone pulse; after release, operation SHALL resume only from IDLE via REQ-019.

Verification
REQ-034 Nominal frame, IMAGE_W=4, IMAGE_H=2, PIPE_LAT=3 -> OutClr pulses 1 clock after Vs rise; OutFrameDone pulses 3 clocks after the second DE fall; OutErr=0.
REQ-035 A 3-pixel line with IMAGE_W=4 -> OutErr=3'b001 after that DE fall; the frame still completes.
REQ-036 Vs rise during line 1 of ACTIVE -> OutErr[2]=1, OutClr re-pulses, OutLineCnt=0.
REQ-037 InThreshold changed 0x40->0x80 mid-frame -> OutThreshold stays 0x40 until the next Vs rise, then reads 0x80.
REQ-038 Vs pulse with PIPE_LAT=5 -> OutVs equals Vs shifted by exactly 5 clocks in all states.
REQ-039 InVideoRstN=0 for 1 clock during ACTIVE -> all outputs 0 and OutState=0 on the next cycle; no OutFrameDone pulse.
